// File: rtl/vh_stim_pkg.sv
// vh_stim_gen shared types: FSM state, operand field layout,
// LFSR width/step and the fixed corner-case vectors.
package vh_stim_pkg;

  localparam int LFSR_W = 60;
  localparam int NUM_CORNERS = 4;

  localparam int W_A0 = 4;
  localparam int W_A1 = 5;
  localparam int W_A2 = 6;
  localparam int W_A3 = 4;
  localparam int W_A4 = 5;
  localparam int W_A5 = 6;
  localparam int W_B0 = 4;
  localparam int W_B1 = 5;
  localparam int W_B2 = 6;
  localparam int W_B3 = 4;
  localparam int W_B4 = 5;
  localparam int W_B5 = 6;

  localparam int OFF_A0 = 56;
  localparam int OFF_A1 = 51;
  localparam int OFF_A2 = 45;
  localparam int OFF_A3 = 41;
  localparam int OFF_A4 = 36;
  localparam int OFF_A5 = 30;
  localparam int OFF_B0 = 26;
  localparam int OFF_B1 = 21;
  localparam int OFF_B2 = 15;
  localparam int OFF_B3 = 11;
  localparam int OFF_B4 = 6;
  localparam int OFF_B5 = 0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } vh_stim_state_e;

  // one operand half (x0..x5) with each field 0101.. from its LSB
  localparam logic [29:0] HALF_ALT = {
    4'h5, 5'h15, 6'h15, 4'h5, 5'h15, 6'h15
  };

  // one operand half with only each field's MSB set
  localparam logic [29:0] HALF_MSB = {
    4'h8, 5'h10, 6'h20, 4'h8, 5'h10, 6'h20
  };

  localparam logic [LFSR_W-1:0] CORNER_ZERO = '0;
  localparam logic [LFSR_W-1:0] CORNER_ONES = '1;
  localparam logic [LFSR_W-1:0] CORNER_ALT =
    {HALF_ALT, HALF_ALT};
  localparam logic [LFSR_W-1:0] CORNER_MSB =
    {HALF_MSB, HALF_MSB};

  // x^60 + x^59 + 1, Fibonacci form, shifting left
  function automatic logic [LFSR_W-1:0] lfsr_next(
    input logic [LFSR_W-1:0] s
  );
    lfsr_next = {s[LFSR_W-2:0], s[59] ^ s[58]};
  endfunction

  function automatic logic [LFSR_W-1:0] corner_vec(
    input logic [1:0] sel
  );
    corner_vec = CORNER_ZERO;
    unique case (sel)
      2'd0: corner_vec = CORNER_ZERO;
      2'd1: corner_vec = CORNER_ONES;
      2'd2: corner_vec = CORNER_ALT;
      2'd3: corner_vec = CORNER_MSB;
    endcase
  endfunction

endpackage

// File: rtl/vh_lfsr60.sv
// 60-bit maximal-length LFSR with synchronous load and step
// enable; load takes priority over step.
module vh_lfsr60
  import vh_stim_pkg::*;
#(
  parameter logic [LFSR_W-1:0] RST_VAL = 60'h1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [LFSR_W-1:0] load_val,
  input  logic              step,
  output logic [LFSR_W-1:0] state
);

  // shift register: reset, load, or advance one step
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RST_VAL;
    end else if (load) begin
      state <= load_val;
    end else if (step) begin
      state <= lfsr_next(state);
    end
  end

endmodule

// File: rtl/vh_stim_gen.sv
// Operand vector source for vloghammer expression blocks.
// Define VH_STIM_CORNER_EN to prepend 4 fixed corner vectors.
module vh_stim_gen
  import vh_stim_pkg::*;
#(
  parameter int NUM_VECTORS = 256,
  parameter logic [LFSR_W-1:0] SEED = 60'h0F0F_1234_5678_9AB
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               ready,
  output logic               valid,
  output logic        [3:0]  a0,
  output logic        [4:0]  a1,
  output logic        [5:0]  a2,
  output logic signed [3:0]  a3,
  output logic signed [4:0]  a4,
  output logic signed [5:0]  a5,
  output logic        [3:0]  b0,
  output logic        [4:0]  b1,
  output logic        [5:0]  b2,
  output logic signed [3:0]  b3,
  output logic signed [4:0]  b4,
  output logic signed [5:0]  b5,
  output logic        [15:0] idx,
  output logic               busy,
  output logic               done
);

  // an all-zero state would lock the LFSR up
  localparam logic [LFSR_W-1:0] SEED_EFF =
    (SEED == '0) ? 60'h1 : SEED;

  localparam logic [15:0] LAST_IDX = 16'(NUM_VECTORS - 1);

  vh_stim_state_e    state;
  logic [LFSR_W-1:0] vec;
  logic [LFSR_W-1:0] lfsr_q;
  logic [LFSR_W-1:0] vec_first;
  logic [LFSR_W-1:0] vec_next;
  logic              launch;
  logic              hs;
  logic              lfsr_step;

  assign launch = start &&
                  (state == ST_IDLE || state == ST_DONE);
  assign hs     = (state == ST_RUN) && ready;

`ifdef VH_STIM_CORNER_EN
  // the LFSR only advances once its own output is on vec
  assign lfsr_step = hs && (idx >= 16'(NUM_CORNERS));
  assign vec_first = CORNER_ZERO;

  // corner patterns first, then SEED, then LFSR sequence
  always_comb begin
    vec_next = lfsr_next(lfsr_q);
    if (idx < 16'(NUM_CORNERS - 1)) begin
      vec_next = corner_vec(2'(idx[1:0] + 2'd1));
    end else if (idx == 16'(NUM_CORNERS - 1)) begin
      vec_next = lfsr_q;
    end
  end
`else
  assign lfsr_step = hs;
  assign vec_first = SEED_EFF;

  // lfsr_q always equals the vector currently on vec
  always_comb begin
    vec_next = lfsr_next(lfsr_q);
  end
`endif

  vh_lfsr60 #(
    .RST_VAL (SEED_EFF)
  ) u_lfsr (
    .clk      (clk),
    .rst      (rst),
    .load     (launch),
    .load_val (SEED_EFF),
    .step     (lfsr_step),
    .state    (lfsr_q)
  );

  // run control FSM with registered handshake/status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      valid <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      idx   <= '0;
      vec   <= '0;
    end else begin
      unique case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state <= ST_RUN;
            valid <= 1'b1;
            busy  <= 1'b1;
            done  <= 1'b0;
            idx   <= '0;
            vec   <= vec_first;
          end
        end
        ST_RUN: begin
          if (ready) begin
            idx <= idx + 16'd1;
            vec <= vec_next;
            if (idx == LAST_IDX) begin
              state <= ST_DONE;
              valid <= 1'b0;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          valid <= 1'b0;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  assign a0 = vec[OFF_A0 +: W_A0];
  assign a1 = vec[OFF_A1 +: W_A1];
  assign a2 = vec[OFF_A2 +: W_A2];
  assign a3 = $signed(vec[OFF_A3 +: W_A3]);
  assign a4 = $signed(vec[OFF_A4 +: W_A4]);
  assign a5 = $signed(vec[OFF_A5 +: W_A5]);
  assign b0 = vec[OFF_B0 +: W_B0];
  assign b1 = vec[OFF_B1 +: W_B1];
  assign b2 = vec[OFF_B2 +: W_B2];
  assign b3 = $signed(vec[OFF_B3 +: W_B3]);
  assign b4 = $signed(vec[OFF_B4 +: W_B4]);
  assign b5 = $signed(vec[OFF_B5 +: W_B5]);

endmodule

// File: tb/tb_vh_stim_gen.sv
// Directed bench for vh_stim_gen: four instances with
// different SEED/NUM_VECTORS, each driven independently.
module tb_vh_stim_gen;

  localparam logic [59:0] S_ONE = 60'h1;
  localparam logic [59:0] S_B59 = 60'h800_0000_0000_0000;
  localparam logic [59:0] S_DEF = 60'h0F0F_1234_5678_9AB;
  localparam logic [59:0] S_ZERO = 60'h0;

  localparam logic [29:0] H_ALT = {
    4'h5, 5'h15, 6'h15, 4'h5, 5'h15, 6'h15
  };
  localparam logic [29:0] H_MSB = {
    4'h8, 5'h10, 6'h20, 4'h8, 5'h10, 6'h20
  };

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst   [4];
  logic        start [4];
  logic        ready [4];
  logic        valid [4];
  logic        busy  [4];
  logic        done  [4];
  logic [15:0] idx   [4];
  logic [3:0]  a0 [4];
  logic [4:0]  a1 [4];
  logic [5:0]  a2 [4];
  logic [3:0]  a3 [4];
  logic [4:0]  a4 [4];
  logic [5:0]  a5 [4];
  logic [3:0]  b0 [4];
  logic [4:0]  b1 [4];
  logic [5:0]  b2 [4];
  logic [3:0]  b3 [4];
  logic [4:0]  b4 [4];
  logic [5:0]  b5 [4];
  logic [59:0] vec [4];

  int n_vec = 0;
  int n_bad = 0;

  for (genvar k = 0; k < 4; k++) begin : g_vec
    assign vec[k] = {a0[k], a1[k], a2[k], a3[k], a4[k],
                     a5[k], b0[k], b1[k], b2[k], b3[k],
                     b4[k], b5[k]};
  end

  vh_stim_gen #(.NUM_VECTORS(4), .SEED(S_ONE)) u_dut0 (
    .clk(clk), .rst(rst[0]), .start(start[0]),
    .ready(ready[0]), .valid(valid[0]),
    .a0(a0[0]), .a1(a1[0]), .a2(a2[0]),
    .a3(a3[0]), .a4(a4[0]), .a5(a5[0]),
    .b0(b0[0]), .b1(b1[0]), .b2(b2[0]),
    .b3(b3[0]), .b4(b4[0]), .b5(b5[0]),
    .idx(idx[0]), .busy(busy[0]), .done(done[0])
  );

  vh_stim_gen #(.NUM_VECTORS(8), .SEED(S_B59)) u_dut1 (
    .clk(clk), .rst(rst[1]), .start(start[1]),
    .ready(ready[1]), .valid(valid[1]),
    .a0(a0[1]), .a1(a1[1]), .a2(a2[1]),
    .a3(a3[1]), .a4(a4[1]), .a5(a5[1]),
    .b0(b0[1]), .b1(b1[1]), .b2(b2[1]),
    .b3(b3[1]), .b4(b4[1]), .b5(b5[1]),
    .idx(idx[1]), .busy(busy[1]), .done(done[1])
  );

  vh_stim_gen u_dut2 (
    .clk(clk), .rst(rst[2]), .start(start[2]),
    .ready(ready[2]), .valid(valid[2]),
    .a0(a0[2]), .a1(a1[2]), .a2(a2[2]),
    .a3(a3[2]), .a4(a4[2]), .a5(a5[2]),
    .b0(b0[2]), .b1(b1[2]), .b2(b2[2]),
    .b3(b3[2]), .b4(b4[2]), .b5(b5[2]),
    .idx(idx[2]), .busy(busy[2]), .done(done[2])
  );

  vh_stim_gen #(.NUM_VECTORS(1), .SEED(S_ZERO)) u_dut3 (
    .clk(clk), .rst(rst[3]), .start(start[3]),
    .ready(ready[3]), .valid(valid[3]),
    .a0(a0[3]), .a1(a1[3]), .a2(a2[3]),
    .a3(a3[3]), .a4(a4[3]), .a5(a5[3]),
    .b0(b0[3]), .b1(b1[3]), .b2(b2[3]),
    .b3(b3[3]), .b4(b4[3]), .b5(b5[3]),
    .idx(idx[3]), .busy(busy[3]), .done(done[3])
  );

  function automatic logic [59:0] model(
    input logic [59:0] seed,
    input int i
  );
    logic [59:0] s;
    int n;
    s = (seed == 60'h0) ? 60'h1 : seed;
    n = i;
`ifdef VH_STIM_CORNER_EN
    if (i == 0) return 60'h0;
    if (i == 1) return {60{1'b1}};
    if (i == 2) return {H_ALT, H_ALT};
    if (i == 3) return {H_MSB, H_MSB};
    n = i - 4;
`endif
    for (int j = 0; j < n; j++) s = {s[58:0], s[59] ^ s[58]};
    return s;
  endfunction

  task automatic chk(
    input string tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_run(
    input int k,
    input string tag,
    input int i,
    input logic [59:0] seed
  );
    chk($sformatf("%s vec%0d", tag, i), 64'(vec[k]),
        64'(model(seed, i)));
    chk($sformatf("%s idx%0d", tag, i), 64'(idx[k]), 64'(i));
    chk($sformatf("%s valid%0d", tag, i), 64'(valid[k]), 64'd1);
    chk($sformatf("%s busy%0d", tag, i), 64'(busy[k]), 64'd1);
  endtask

  task automatic chk_done(input int k, input string tag);
    chk({tag, " done"}, 64'(done[k]), 64'd1);
    chk({tag, " valid"}, 64'(valid[k]), 64'd0);
    chk({tag, " busy"}, 64'(busy[k]), 64'd0);
  endtask

  task automatic chk_idle(input int k, input string tag);
    chk({tag, " valid"}, 64'(valid[k]), 64'd0);
    chk({tag, " busy"}, 64'(busy[k]), 64'd0);
    chk({tag, " done"}, 64'(done[k]), 64'd0);
    chk({tag, " idx"}, 64'(idx[k]), 64'd0);
    chk({tag, " vec"}, 64'(vec[k]), 64'd0);
  endtask

  initial begin
    for (int k = 0; k < 4; k++) begin
      rst[k] = 1'b1;
      start[k] = 1'b0;
      ready[k] = 1'b0;
    end
    repeat (2) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      chk_idle(k, $sformatf("reset%0d", k));
      rst[k] = 1'b0;
    end

    // basic run, SEED=1, 4 vectors
    ready[0] = 1'b1;
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk_run(0, "basic", i, S_ONE);
      @(negedge clk);
    end
    chk_done(0, "basic");

    // restart from DONE, start held into RUN is ignored
    start[0] = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk_run(0, "restart", i, S_ONE);
      if (i == 2) start[0] = 1'b0;
      @(negedge clk);
    end
    chk_done(0, "restart");

    // feedback bit, backpressure, reset mid-run
    ready[1] = 1'b1;
    start[1] = 1'b1;
    @(negedge clk);
    start[1] = 1'b0;
    chk_run(1, "fb", 0, S_B59);
    @(negedge clk);
    chk_run(1, "fb", 1, S_B59);
    ready[1] = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk_run(1, "bp", 1, S_B59);
    end
    ready[1] = 1'b1;
    @(negedge clk);
    chk_run(1, "bp", 2, S_B59);
    rst[1] = 1'b1;
    @(negedge clk);
    chk_idle(1, "midrst");
    rst[1] = 1'b0;
    start[1] = 1'b1;
    @(negedge clk);
    start[1] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk_run(1, "replay", i, S_B59);
      @(negedge clk);
    end
    chk_done(1, "replay");

    // start and rst together in DONE: rst wins
    start[1] = 1'b1;
    rst[1] = 1'b1;
    @(negedge clk);
    start[1] = 1'b0;
    rst[1] = 1'b0;
    chk_idle(1, "rstwin");

    // default parameters
    ready[2] = 1'b1;
    start[2] = 1'b1;
    @(negedge clk);
    start[2] = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk_run(2, "deflt", i, S_DEF);
`ifdef VH_STIM_CORNER_EN
      if (i == 1) begin
        chk("corner a3", 64'(a3[2]), 64'h0F);
        chk("corner b5", 64'(b5[2]), 64'h3F);
      end
      if (i == 3) chk("corner a5", 64'(a5[2]), 64'h20);
      if (i == 4) chk("corner seed", 64'(vec[2]), 64'(S_DEF));
`else
      if (i == 0) chk("seed v0", 64'(vec[2]), 64'(S_DEF));
`endif
      @(negedge clk);
    end

    // SEED=0 replaced by 1, single-vector run
    ready[3] = 1'b1;
    start[3] = 1'b1;
    @(negedge clk);
    start[3] = 1'b0;
    chk_run(3, "seed0", 0, S_ZERO);
    @(negedge clk);
    chk_done(3, "seed0");

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
